fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding request, one-entry skid buffer, redirect flush.
// Optional FETCH_STATS_EN macro adds fetch_count / flush_count outputs.
//
// state | meaning
// BOOT  | first cycle after reset, no request
// FETCH | request at pc outstanding, deliver on ack
// HOLD  | skid buffer holds a fetched word while downstream stalls
// DROP  | redirected while a request was outstanding; discard its response
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  output logic        out_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] skid_addr;
  logic [31:0] skid_instr;
  logic        skid_valid;
  logic        deliver;

  assign imem_req = (state == FETCH) || (state == DROP);
  // In DROP the abandoned request must stay stable while pc already holds the target.
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  assign deliver = !redirect_valid && !stall &&
                   (((state == FETCH) && imem_ack) || (state == HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      drop_addr  <= 32'h0;
      skid_addr  <= 32'h0;
      skid_instr <= 32'h0;
      skid_valid <= 1'b0;
      out_addr   <= 32'h0;
      out_instr  <= 32'h0;
      out_valid  <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc & ~32'h3;
      out_addr   <= 32'h0;
      out_instr  <= 32'h0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (!imem_ack) begin
            state     <= DROP;
            drop_addr <= pc;
          end else begin
            state <= FETCH;
          end
        end
        DROP:    state <= DROP;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc <= pc + 32'd4;
            if (stall) begin
              skid_addr  <= pc;
              skid_instr <= imem_rdata;
              skid_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              out_addr  <= pc;
              out_instr <= imem_rdata;
              out_valid <= 1'b1;
            end
          end else if (!stall) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_addr   <= skid_addr;
            out_instr  <= skid_instr;
            out_valid  <= skid_valid;
            skid_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        default: begin
          if (imem_ack) state <= FETCH;
          if (!stall) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
          end
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'h0;
      flush_count <= 16'h0;
    end else begin
      if (deliver)        fetch_count <= fetch_count + 32'd1;
      if (redirect_valid) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
